// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the CPU/memory side and the sprite DMA engine.
// The master side is the CPU bus and memory; the slave side is the DMA engine.
interface oam_dma_ctrl_if;
  logic        cpu_ce;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic [7:0]  oam_start;
  logic [7:0]  mem_data_in;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        oam_dma;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_out;
  logic        busy;

  modport master (
    output cpu_ce, cpu_we, cpu_addr, cpu_data_in, oam_start, mem_data_in,
    input  cpu_stall, mem_addr, mem_rd, oam_dma, oam_addr, oam_data_out, busy
  );

  modport slave (
    input  cpu_ce, cpu_we, cpu_addr, cpu_data_in, oam_start, mem_data_in,
    output cpu_stall, mem_addr, mem_rd, oam_dma, oam_addr, oam_data_out, busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine for the $4014 register.
// A CPU write of page P halts the CPU and copies P*256..P*256+255 into OAM,
// one byte per READ/WRITE pair of CPU cycles, starting at the current OAMADDR.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014
) (
  input  logic          clk,
  input  logic          reset,
  oam_dma_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state;
  logic       parity;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] base;
  logic [7:0] data_reg;
  logic       trigger;

  assign trigger = bus.cpu_ce & bus.cpu_we & (bus.cpu_addr == TRIG_ADDR);

  // CPU cycle parity, toggling on every CPU cycle regardless of DMA state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (bus.cpu_ce) begin
      parity <= ~parity;
    end
  end

  // Capture the memory read data one clk after the read request is presented.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg <= 8'h00;
    end else if (bus.mem_rd) begin
      data_reg <= bus.mem_data_in;
    end
  end

  // Transfer sequencer with registered bus and OAM outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      idx              <= 8'h00;
      page             <= 8'h00;
      base             <= 8'h00;
      bus.cpu_stall    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.mem_rd       <= 1'b0;
      bus.mem_addr     <= 16'h0000;
      bus.oam_dma      <= 1'b0;
      bus.oam_addr     <= 8'h00;
      bus.oam_data_out <= 8'h00;
    end else begin
      bus.oam_dma <= 1'b0;
      if (bus.cpu_ce) begin
        case (state)
          IDLE: begin
            if (trigger) begin
              page          <= bus.cpu_data_in;
              base          <= bus.oam_start;
              idx           <= 8'h00;
              state         <= HALT;
              bus.cpu_stall <= 1'b1;
              bus.busy      <= 1'b1;
            end
          end
          HALT: begin
            // The HALT cycle's parity is the current one; reads must start on
            // an even cycle, so an even HALT cycle needs one ALIGN cycle.
            if (parity) begin
              state        <= READ;
              bus.mem_rd   <= 1'b1;
              bus.mem_addr <= {page, idx};
            end else begin
              state <= ALIGN;
            end
          end
          ALIGN: begin
            state        <= READ;
            bus.mem_rd   <= 1'b1;
            bus.mem_addr <= {page, idx};
          end
          READ: begin
            state        <= WRITE;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= 16'h0000;
          end
          WRITE: begin
            bus.oam_dma      <= 1'b1;
            bus.oam_addr     <= base + idx;
            bus.oam_data_out <= data_reg;
            if (idx == 8'hFF) begin
              state         <= IDLE;
              bus.cpu_stall <= 1'b0;
              bus.busy      <= 1'b0;
            end else begin
              idx          <= idx + 8'd1;
              state        <= READ;
              bus.mem_rd   <= 1'b1;
              bus.mem_addr <= {page, idx + 8'd1};
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for the $4014 sprite DMA engine.
module tb_oam_dma_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(.TRIG_ADDR(16'h4014)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.mem_data_in = mem[bus.mem_addr];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_stall;
    logic        exp_rd;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  int compared   = 0;
  int mismatched = 0;
  int ce_count   = 0;
  int stall_ces  = 0;
  int n_wr       = 0;
  int width_err  = 0;
  int page_err   = 0;
  logic       prev_dma = 1'b0;
  logic [7:0] exp_page = 8'h00;
  logic [7:0] wr_addr [0:511];
  logic [7:0] wr_data [0:511];

  // Observe the DUT half a clock away from the active edge.
  always @(negedge clk) begin
    if (bus.cpu_ce && bus.cpu_stall) stall_ces++;
    if (bus.oam_dma) begin
      if (n_wr < 512) begin
        wr_addr[n_wr] = bus.oam_addr;
        wr_data[n_wr] = bus.oam_data_out;
      end
      n_wr++;
      if (prev_dma) width_err++;
    end
    prev_dma = bus.oam_dma;
    if (bus.mem_rd && (bus.mem_addr[15:8] != exp_page)) page_err++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One CPU cycle: cpu_ce high for one clk, then low for one clk.
  task automatic apply_stimulus(input logic we, input logic [15:0] addr, input logic [7:0] data);
    bus.cpu_ce      = 1'b1;
    bus.cpu_we      = we;
    bus.cpu_addr    = addr;
    bus.cpu_data_in = data;
    @(posedge clk); #1;
    bus.cpu_ce      = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_data_in = 8'h00;
    @(posedge clk); #1;
    ce_count++;
  endtask

  task automatic do_reset();
    bus.cpu_ce = 1'b0;
    bus.cpu_we = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    ce_count = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_stall"}, 32'(bus.cpu_stall), 0);
    check_output({tag, "_busy"}, 32'(bus.busy), 0);
    check_output({tag, "_mem_rd"}, 32'(bus.mem_rd), 0);
    check_output({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    check_output({tag, "_oam_dma"}, 32'(bus.oam_dma), 0);
    check_output({tag, "_oam_addr"}, 32'(bus.oam_addr), 0);
    check_output({tag, "_oam_data"}, 32'(bus.oam_data_out), 0);
  endtask

  // Full transfer with optional retrigger; checks stall length and OAM contents.
  task automatic run_transfer(input logic [7:0] pg, input logic [7:0] start, input int par,
                              input int retrig_at, input int exp_stall, input string tag);
    int n;
    int bad;
    logic [7:0] ea;
    logic [7:0] ed;
    bus.oam_start = start;
    exp_page = pg;
    if ((ce_count % 2) != par) apply_stimulus(1'b0, 16'h0000, 8'h00);
    stall_ces = 0;
    n_wr = 0;
    width_err = 0;
    page_err = 0;
    apply_stimulus(1'b1, 16'h4014, pg);
    n = 0;
    while (bus.cpu_stall && n < 700) begin
      if (n == retrig_at) apply_stimulus(1'b1, 16'h4014, 8'h03);
      else apply_stimulus(1'b0, 16'h0000, 8'h00);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check_output({tag, "_finished"}, 32'(bus.cpu_stall), 0);
    check_output({tag, "_busy_end"}, 32'(bus.busy), 0);
    check_output({tag, "_stall_ces"}, 32'(stall_ces), 32'(exp_stall));
    check_output({tag, "_oam_writes"}, 32'(n_wr), 256);
    check_output({tag, "_pulse_width"}, 32'(width_err), 0);
    check_output({tag, "_read_page"}, 32'(page_err), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      ea = start + 8'(i);
      ed = mem[{pg, 8'(i)}];
      if (wr_addr[i] !== ea || wr_data[i] !== ed) bad++;
    end
    check_output({tag, "_bad_writes"}, 32'(bad), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus.cpu_ce      = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_data_in = 8'h00;
    bus.oam_start   = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0300 + i] = 8'hEE;
      mem[16'h0500 + i] = 8'(i + 1);
      mem[16'h0700 + i] = 8'(i * 7 + 3);
      mem[16'h0900 + i] = 8'(255 - i);
    end

    //                 we    addr      data   stall rd   mem_addr
    vecs[0] = '{1'b1, 16'h4015, 8'h02, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 16'h2014, 8'h02, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 16'h4014, 8'h02, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 16'h4000, 8'h02, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 16'h4014, 8'h05, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0500};
    vecs[6] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0501};
    vecs[8] = '{1'b1, 16'h4014, 8'h09, 1'b1, 1'b0, 16'h0000};
    vecs[9] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0502};

    do_reset();
    check_all_zero("reset");

    exp_page = 8'h05;
    for (int v = 0; v < 10; v++) begin
      apply_stimulus(vecs[v].we, vecs[v].addr, vecs[v].data);
      check_output($sformatf("vec%0d_stall", v), 32'(bus.cpu_stall), 32'(vecs[v].exp_stall));
      check_output($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(vecs[v].exp_stall));
      check_output($sformatf("vec%0d_mem_rd", v), 32'(bus.mem_rd), 32'(vecs[v].exp_rd));
      check_output($sformatf("vec%0d_mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].exp_addr));
    end

    do_reset();
    run_transfer(8'h02, 8'h00, 0, -1, 513, "even");
    run_transfer(8'h02, 8'h00, 1, -1, 514, "odd");
    run_transfer(8'h07, 8'hFC, 0, -1, 513, "wrap");
    check_output("wrap_first_addr", 32'(wr_addr[0]), 32'h00FC);
    check_output("wrap_first_data", 32'(wr_data[0]), 32'(mem[16'h0700]));
    check_output("wrap_zero_addr", 32'(wr_addr[4]), 32'h0000);
    check_output("wrap_zero_data", 32'(wr_data[4]), 32'(mem[16'h0704]));
    check_output("wrap_last_addr", 32'(wr_addr[255]), 32'h00FB);
    check_output("wrap_last_data", 32'(wr_data[255]), 32'(mem[16'h07FF]));
    run_transfer(8'h02, 8'h00, 0, 99, 513, "retrig");

    // Reset after 40 OAM writes aborts the transfer immediately.
    bus.oam_start = 8'h00;
    exp_page = 8'h02;
    n_wr = 0;
    apply_stimulus(1'b1, 16'h4014, 8'h02);
    n = 0;
    while (n_wr < 40 && n < 200) begin
      apply_stimulus(1'b0, 16'h0000, 8'h00);
      n++;
    end
    check_output("abort_writes_before", 32'(n_wr), 40);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("abort");
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    ce_count = 0;
    repeat (4) @(posedge clk);
    #1;
    check_output("abort_writes_after", 32'(n_wr), 40);
    check_output("abort_idle_stall", 32'(bus.cpu_stall), 0);
    run_transfer(8'h02, 8'h00, 1, -1, 514, "post_reset");

    // Trigger on the final WRITE cycle is ignored; the next one is accepted.
    bus.oam_start = 8'h00;
    exp_page = 8'h02;
    n_wr = 0;
    apply_stimulus(1'b1, 16'h4014, 8'h02);
    n = 0;
    while (n_wr < 255 && n < 700) begin
      apply_stimulus(1'b0, 16'h0000, 8'h00);
      n++;
    end
    apply_stimulus(1'b0, 16'h0000, 8'h00);
    check_output("edge_still_stalled", 32'(bus.cpu_stall), 1);
    apply_stimulus(1'b1, 16'h4014, 8'h09);
    check_output("edge_final_writes", 32'(n_wr), 256);
    check_output("edge_ignored_stall", 32'(bus.cpu_stall), 0);
    exp_page = 8'h09;
    page_err = 0;
    apply_stimulus(1'b1, 16'h4014, 8'h09);
    check_output("edge_accepted_stall", 32'(bus.cpu_stall), 1);
    check_output("edge_accepted_busy", 32'(bus.busy), 1);
    n = 0;
    while (bus.cpu_stall && n < 700) begin
      apply_stimulus(1'b0, 16'h0000, 8'h00);
      n++;
    end
    check_output("edge_second_done", 32'(bus.cpu_stall), 0);
    check_output("edge_second_page", 32'(page_err), 0);
    check_output("edge_second_writes", 32'(n_wr), 512);
    check_output("edge_second_last_data", 32'(wr_data[511]), 32'(mem[16'h09FF]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
